// File: rtl/mix_act_if.sv
// Bus bundle between the mix-layer dot/bias unit and the hard-tanh activation stage.
// Master drives the request side; slave returns the activated vector and derivative mask.
interface mix_act_if #(
    parameter int N_LEN   = 16,
    parameter int HID_DIM = 24
);
    logic                       run;
    logic                       d_valid;
    logic [HID_DIM*N_LEN-1:0]   d;
    logic                       valid;
    logic [HID_DIM*N_LEN-1:0]   q;
    logic [HID_DIM-1:0]         mask;

    modport master (output run, d_valid, d, input valid, q, mask);
    modport slave  (input run, d_valid, d, output valid, q, mask);
endinterface

// File: rtl/mix_act.sv
// Hard-tanh activation stage: captures a fixed-point vector, clamps it to [-1.0, +1.0]
// one element per cycle, and exports the activated vector plus a backward-pass derivative mask.
module mix_act #(
    parameter int N_LEN   = 16,
    parameter int F_LEN   = 8,
    parameter int HID_DIM = 24
) (
    input  logic     clk,
    input  logic     rst_n,
    mix_act_if.slave bus
);
    localparam int IDX_W = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
    localparam int VEC_W = HID_DIM * N_LEN;
    localparam logic signed [N_LEN-1:0] ONE = N_LEN'(1'b1) << F_LEN;
    localparam logic signed [N_LEN-1:0] NEG = -ONE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [VEC_W-1:0]        buf_q, buf_d;
    logic [VEC_W-1:0]        q_q, q_d;
    logic [HID_DIM-1:0]      mask_q, mask_d;
    logic signed [N_LEN-1:0] elem_s;
    logic [N_LEN:0]          act_s;

    // Returns {mask_bit, activated_value}; exact +/-1.0 and anything beyond saturate with mask 0.
    function automatic logic [N_LEN:0] hard_tanh(input logic signed [N_LEN-1:0] x);
        logic [N_LEN:0] r;
        if (x >= ONE) begin
            r = {1'b0, ONE};
        end else if (x <= NEG) begin
            r = {1'b0, NEG};
        end else begin
            r = {1'b1, x};
        end
        return r;
    endfunction

    assign elem_s    = buf_q[idx_q*N_LEN +: N_LEN];
    assign act_s     = hard_tanh(elem_s);
    assign bus.q     = q_q;
    assign bus.mask  = mask_q;
    assign bus.valid = bus.run & (state_q == S_DONE);

    // State, index, capture buffer and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            q_q     <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            q_q     <= q_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state and datapath; dropping run aborts from any state but keeps the data registers.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        q_d     = q_q;
        mask_d  = mask_q;
        if (!bus.run) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.d_valid) begin
                        buf_d   = bus.d;
                        idx_d   = '0;
                        state_d = S_ACT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ACT: begin
                    q_d[idx_q*N_LEN +: N_LEN] = act_s[N_LEN-1:0];
                    mask_d[idx_q]             = act_s[N_LEN];
                    if (idx_q == IDX_W'(HID_DIM - 1)) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1'b1);
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mix_act.sv
// Directed self-checking bench for the hard-tanh activation stage.
module tb_mix_act;
    localparam int N_LEN   = 16;
    localparam int F_LEN   = 8;
    localparam int HID_DIM = 24;
    localparam int W       = HID_DIM * N_LEN;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    logic [W-1:0]       exp_q1;
    logic [HID_DIM-1:0] exp_m1;

    mix_act_if #(.N_LEN(N_LEN), .HID_DIM(HID_DIM)) bus ();

    mix_act #(.N_LEN(N_LEN), .F_LEN(F_LEN), .HID_DIM(HID_DIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [W-1:0] fill(input logic [N_LEN-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < HID_DIM; i++) r[i*N_LEN +: N_LEN] = v;
        return r;
    endfunction

    // Capture vec, then count cycles until valid rises (-1 on timeout).
    task automatic run_op(input logic [W-1:0] vec, output int lat);
        bus.d       = vec;
        bus.run     = 1'b1;
        bus.d_valid = 1'b1;
        @(posedge clk); #1;
        bus.d_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.run = 1'b0; bus.d_valid = 1'b0; bus.d = '0;
        rst_n = 1'b0;
        #12;
        total_cnt++; if (bus.q !== '0) $display("FAIL reset_q: got %h want 0", bus.q); else pass_cnt++;
        total_cnt++; if (bus.mask !== '0) $display("FAIL reset_mask: got %h want 0", bus.mask); else pass_cnt++;
        total_cnt++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clamp();
        logic [W-1:0] v;
        int lat;
        logic [N_LEN-1:0] din [6]  = '{16'h0080, 16'h0300, 16'hFD00, 16'h0100, 16'hFF01, 16'h8000};
        logic [N_LEN-1:0] dexp [6] = '{16'h0080, 16'h0100, 16'hFF00, 16'h0100, 16'hFF01, 16'hFF00};
        v = '0; exp_q1 = '0;
        for (int i = 0; i < 6; i++) begin
            v[i*N_LEN +: N_LEN]      = din[i];
            exp_q1[i*N_LEN +: N_LEN] = dexp[i];
        end
        exp_m1 = 24'hFFFFD1;
        run_op(v, lat);
        total_cnt++; if (lat !== 24) $display("FAIL clamp_latency: got %0d want 24", lat); else pass_cnt++;
        for (int i = 0; i < HID_DIM; i++) begin
            total_cnt++;
            if (bus.q[i*N_LEN +: N_LEN] !== exp_q1[i*N_LEN +: N_LEN])
                $display("FAIL clamp_q[%0d]: got %h want %h", i, bus.q[i*N_LEN +: N_LEN], exp_q1[i*N_LEN +: N_LEN]);
            else pass_cnt++;
        end
        total_cnt++; if (bus.mask !== exp_m1) $display("FAIL clamp_mask: got %h want %h", bus.mask, exp_m1); else pass_cnt++;
    endtask

    task automatic test_done_hold();
        logic ok;
        ok = 1'b1;
        bus.d = fill(16'h0050);
        bus.d_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.valid !== 1'b1) ok = 1'b0;
        end
        bus.d_valid = 1'b0;
        total_cnt++; if (ok !== 1'b1) $display("FAIL done_valid_hold: got %b want 1", ok); else pass_cnt++;
        total_cnt++; if (bus.q !== exp_q1) $display("FAIL done_q_hold: got %h want %h", bus.q, exp_q1); else pass_cnt++;
        total_cnt++; if (bus.mask !== exp_m1) $display("FAIL done_mask_hold: got %h want %h", bus.mask, exp_m1); else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [W-1:0] eq;
        int lat;
        bus.run = 1'b0;
        #1;
        total_cnt++; if (bus.valid !== 1'b0) $display("FAIL abort_valid_comb: got %b want 0", bus.valid); else pass_cnt++;
        @(posedge clk); #1;
        bus.d = fill(16'h0200); bus.run = 1'b1; bus.d_valid = 1'b1;
        @(posedge clk); #1;
        bus.d_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.run = 1'b0;
        #1;
        total_cnt++; if (bus.valid !== 1'b0) $display("FAIL abort_valid_act: got %b want 0", bus.valid); else pass_cnt++;
        @(posedge clk); #1;
        eq = exp_q1;
        for (int i = 0; i < 5; i++) eq[i*N_LEN +: N_LEN] = 16'h0100;
        total_cnt++; if (bus.q !== eq) $display("FAIL abort_q_partial: got %h want %h", bus.q, eq); else pass_cnt++;
        total_cnt++; if (bus.mask !== 24'hFFFFC0) $display("FAIL abort_mask_partial: got %h want ffffc0", bus.mask); else pass_cnt++;
        run_op(fill(16'h0040), lat);
        total_cnt++; if (lat !== 24) $display("FAIL rerun_latency: got %0d want 24", lat); else pass_cnt++;
        total_cnt++; if (bus.q !== fill(16'h0040)) $display("FAIL rerun_q: got %h want all 0040", bus.q); else pass_cnt++;
        total_cnt++; if (bus.mask !== 24'hFFFFFF) $display("FAIL rerun_mask: got %h want ffffff", bus.mask); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bus.run = 1'b0;
        @(posedge clk); #1;
        bus.d = fill(16'h0010); bus.run = 1'b1; bus.d_valid = 1'b1;
        @(posedge clk); #1;
        bus.d_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.q !== '0) $display("FAIL areset_q: got %h want 0", bus.q); else pass_cnt++;
        total_cnt++; if (bus.mask !== '0) $display("FAIL areset_mask: got %h want 0", bus.mask); else pass_cnt++;
        total_cnt++; if (bus.valid !== 1'b0) $display("FAIL areset_valid: got %b want 0", bus.valid); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_idle_hold();
        logic ok;
        int lat;
        ok = 1'b1;
        bus.d = fill(16'h0033); bus.run = 1'b1; bus.d_valid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (bus.valid !== 1'b0 || bus.q !== '0) ok = 1'b0;
        end
        total_cnt++; if (ok !== 1'b1) $display("FAIL idle_hold: got %b want 1", ok); else pass_cnt++;
        run_op(fill(16'h0033), lat);
        total_cnt++; if (lat !== 24) $display("FAIL idle_then_run_latency: got %0d want 24", lat); else pass_cnt++;
        total_cnt++; if (bus.q !== fill(16'h0033)) $display("FAIL idle_then_run_q: got %h want all 0033", bus.q); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vb;
        int lat;
        bus.run = 1'b0;
        @(posedge clk); #1;
        run_op(fill(16'hFE80), lat);
        total_cnt++; if (lat !== 24) $display("FAIL b2b_a_latency: got %0d want 24", lat); else pass_cnt++;
        total_cnt++; if (bus.q !== fill(16'hFF00)) $display("FAIL b2b_a_q: got %h want all ff00", bus.q); else pass_cnt++;
        total_cnt++; if (bus.mask !== 24'h000000) $display("FAIL b2b_a_mask: got %h want 000000", bus.mask); else pass_cnt++;
        for (int i = 0; i < HID_DIM; i++) vb[i*N_LEN +: N_LEN] = (i % 2 == 0) ? 16'h00FF : 16'hFF00;
        bus.run = 1'b0;
        @(posedge clk); #1;
        run_op(vb, lat);
        total_cnt++; if (lat !== 24) $display("FAIL b2b_b_latency: got %0d want 24", lat); else pass_cnt++;
        total_cnt++; if (bus.q !== vb) $display("FAIL b2b_b_q: got %h want %h", bus.q, vb); else pass_cnt++;
        total_cnt++; if (bus.mask !== 24'h555555) $display("FAIL b2b_b_mask: got %h want 555555", bus.mask); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_clamp();
        test_done_hold();
        test_abort();
        test_async_reset();
        test_idle_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
